// File: rtl/conv_seq_ctrl.sv
// Frame sequencer for a padded-image convolution engine: restart the row streamer, wait for fill,
// run a fixed beat schedule plus drain, repeat per frame. Optional FILL watchdog: CONV_SEQ_TIMEOUT_EN.
module conv_seq_ctrl #(
  parameter int unsigned IMG     = 14,
  parameter int unsigned PAD     = 1,
  parameter int unsigned DRAIN   = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] nframes,
  input  logic       abort,
  input  logic       srt_sig,
  output logic       load,
  output logic       sa_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_idx,
  output logic       err
);
  localparam int unsigned SIZE       = IMG + 2 * PAD;
  localparam int unsigned BEATS      = SIZE * (SIZE - 2);
  localparam logic [15:0] LAST_BEAT  = 16'(BEATS - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(DRAIN - 1);

  if (SIZE < 3) begin : g_chk_size
    $error("conv_seq_ctrl: padded side SIZE must be at least 3");
  end
  if (BEATS > 65535) begin : g_chk_beats
    $error("conv_seq_ctrl: SIZE*(SIZE-2) does not fit the 16-bit beat counter");
  end
  if (TIMEOUT == 0) begin : g_chk_timeout
    $error("conv_seq_ctrl: TIMEOUT must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FILL, S_STREAM, S_DRAIN, S_NEXT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] drain_q, drain_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  nfr_q, nfr_d;
  logic        fill_first_q, fill_first_d;
  logic        done_q, done_d;

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int unsigned   TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] fill_cnt_q, fill_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    drain_d      = drain_q;
    frame_d      = frame_q;
    nfr_d        = nfr_q;
    fill_first_d = 1'b0;
    done_d       = 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          nfr_d   = (nframes == 8'd0) ? 8'd1 : nframes;
          frame_d = 8'd0;
`ifdef CONV_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        state_d      = S_FILL;
        fill_first_d = 1'b1;
      end
      S_FILL: begin
        // The streamer's valid flag is still high from the previous frame in the first FILL cycle.
        if (!fill_first_q && srt_sig) begin
          state_d = S_STREAM;
        end
`ifdef CONV_SEQ_TIMEOUT_EN
        else if (fill_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      S_STREAM: begin
        beat_d = beat_q + 16'd1;
        if (beat_q == LAST_BEAT) begin
          state_d = (DRAIN == 0) ? S_NEXT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 16'd1;
        if (drain_q == LAST_DRAIN) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (({1'b0, frame_q} + 9'd1) < {1'b0, nfr_q}) begin
          frame_d = frame_q + 8'd1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    if (state_d == S_LOAD || state_d == S_IDLE) begin
      beat_d  = 16'd0;
      drain_d = 16'd0;
    end

`ifdef CONV_SEQ_TIMEOUT_EN
    fill_cnt_d = (state_q == S_FILL && state_d == S_FILL) ? fill_cnt_q + TO_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= 16'd0;
      drain_q      <= 16'd0;
      frame_q      <= 8'd0;
      nfr_q        <= 8'd0;
      fill_first_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      drain_q      <= drain_d;
      frame_q      <= frame_d;
      nfr_q        <= nfr_d;
      fill_first_q <= fill_first_d;
      done_q       <= done_d;
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      err_q      <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign load      = (state_q == S_LOAD);
  assign sa_en     = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign frame_idx = frame_q;

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter IMG, default 14, unpadded image side length.
REQ-002 SHALL have parameter PAD, default 1, zero-pad width per side; SIZE = IMG + 2*PAD.
REQ-003 SHALL have parameter DRAIN, default 2, extra cycles covering the output skew of the row streamer.
REQ-004 SHALL have parameter TIMEOUT, default 1023, the FILL watchdog limit in cycles; used only when the watchdog is compiled in.
REQ-005 SHALL use one clock and an asynchronous active-low reset: port clk (input, 1, rising-edge clock) and port rst_n (input, 1, async active-low reset).
REQ-006 start, input, 1: single-cycle request to process NFRAMES frames.
REQ-007 nframes, input, 8: frame count, sampled on an accepted start; value 0 is treated as 1.
REQ-008 abort, input, 1: synchronous cancel.
REQ-009 srt_sig, input, 1: streamer output-valid flag, which stays high until its next load.
REQ-010 load, output, 1: single-cycle pulse that restarts the streamer.
REQ-011 sa_en, output, 1: systolic-array accumulate enable.
REQ-012 busy, output, 1: high in every state except IDLE.
REQ-013 done, output, 1: single-cycle pulse after the last frame.
REQ-014 frame_idx, output, 8: index of the current frame, 0-based.
REQ-015 err, output, 1: sticky watchdog error flag.

Function
REQ-016 SHALL implement the states IDLE, LOAD, FILL, STREAM, DRAIN and NEXT, all registered.
REQ-017 IDLE -> LOAD when start=1 and abort=0; busy SHALL rise in the cycle after start is sampled; nframes SHALL be latched, frame_idx SHALL be cleared and err SHALL be cleared.
REQ-018 In LOAD, load=1 for exactly 1 cycle, then the block SHALL go to FILL.
REQ-019 In FILL, the block SHALL wait for srt_sig=1, ignoring srt_sig in the first cycle after LOAD (stale high), then go to STREAM.
REQ-020 In STREAM, sa_en=1 and a 16-bit beat counter SHALL increment each cycle; at beat SIZE*(SIZE-2)-1 the block SHALL go to DRAIN.
REQ-021 In DRAIN, sa_en SHALL stay 1 for exactly DRAIN cycles, then the block SHALL go to NEXT.
REQ-022 In NEXT, if frame_idx+1 < latched nframes, frame_idx SHALL increment and the block SHALL go to LOAD; otherwise done=1 for 1 cycle and the block SHALL go to IDLE.
REQ-023 Total sa_en cycles per frame SHALL be SIZE*(SIZE-2)+DRAIN.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge, with sa_en=0, load=0 and no done; abort SHALL take priority over start in the same cycle.
REQ-026 Beat and drain counters SHALL clear on every LOAD entry.
REQ-027 Beat arithmetic SHALL be unsigned 16-bit; an elaboration-time check SHALL fail if SIZE*(SIZE-2) > 65535 or if SIZE < 3.
REQ-028 A srt_sig drop during STREAM SHALL NOT stall counting; the beat schedule is fixed-length.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, load=0, sa_en=0, busy=0, done=0, err=0, frame_idx=0, all counters 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release the block SHALL sit in IDLE until a new start.

Configuration
REQ-031 Macro CONV_SEQ_TIMEOUT_EN, when defined: a FILL-cycle counter SHALL run; reaching TIMEOUT cycles without srt_sig SHALL set err=1 (sticky until the next accepted start or reset) and force IDLE with no done.
REQ-032 Without CONV_SEQ_TIMEOUT_EN: FILL SHALL wait indefinitely, err SHALL be tied 0, and no timeout counter SHALL be synthesized.

Verification (IMG=14, PAD=1, DRAIN=2, so SIZE=16, beats=224)
REQ-033 start with nframes=1; streamer model raises srt_sig 3 cycles after load -> one load pulse, sa_en high for exactly 226 consecutive cycles, one done pulse, then busy=0.
REQ-034 nframes=3 -> three load pulses, frame_idx stepping 0, 1, 2, 678 sa_en cycles in total, exactly one done.
REQ-035 abort at beat 100 of frame 0 -> IDLE next edge, sa_en=0, no done; a subsequent start completes normally.
REQ-036 start repulsed during STREAM, and start plus abort in the same IDLE cycle -> both ignored; state trace unchanged.
REQ-037 With CONV_SEQ_TIMEOUT_EN and TIMEOUT=50, srt_sig held 0 -> err=1 at FILL cycle 50, IDLE, no done; the next start clears err.
REQ-038 rst_n asserted during DRAIN -> all outputs 0 immediately, without waiting for a clock edge.
